// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-access controller: access sizes and FSM states.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        WR,
        RESP
    } mac_state_t;

    // Encoding 3 is reserved and behaves as a word access.
    function automatic mem_size_t norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_WORD : mem_size_t'(sz);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module mem_access_ctrl_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  mem_size_t          i_size,
    input  logic [1:0]         i_lane,
    input  logic               i_unsigned,
    input  logic [DATA_W-1:0]  i_rword,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_load,
    output logic [DATA_W-1:0]  o_merge
);

    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_wd_shift;

    always_comb begin
        w_shamt    = {i_lane, 3'b000};
        w_half     = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
        w_byte     = i_lane[0] ? w_half[15:8] : w_half[7:0];
        w_wd_shift = i_wdata << w_shamt;
        o_load     = i_rword;
        w_mask     = '1;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                w_mask = 32'h0000_00FF << w_shamt;
            end
            SZ_HALF: begin
                o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
                w_mask = 32'h0000_FFFF << w_shamt;
            end
            default: ;
        endcase
        o_merge = (i_rword & ~w_mask) | (w_wd_shift & w_mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for d_mem with sizing, extension and sub-word read-modify-write.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses respond with rsp_err instead of aligning down.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned WIDTH    = DATA_W,
    parameter int unsigned AW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW+1:0]    req_addr,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [AW-1:0]    dataAddress,
    output logic [WIDTH-1:0] writeMemData,
    output logic             memRead,
    output logic             memWrite,
    input  logic [WIDTH-1:0] readMemData
);

    localparam logic [2:0] LAT = 3'(READ_LAT);

    mac_state_t       r_state;
    logic [2:0]       r_cnt;
    mem_size_t        r_size;
    logic [1:0]       r_lane;
    logic             r_unsigned;
    logic [WIDTH-1:0] r_wdata;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_wmem;
    logic             r_mem_rd;
    logic             r_mem_wr;

    mem_size_t        w_size;
    logic [1:0]       w_lane;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_merge;
    logic             w_hit;

    always_comb begin
        w_size = norm_size(req_size);
        w_hit  = (r_cnt == LAT);
        case (w_size)
            SZ_BYTE: w_lane = req_addr[1:0];
            SZ_HALF: w_lane = {req_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_rsp_err;
    assign w_misalign = ((w_size == SZ_HALF) && req_addr[0]) ||
                        ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign rsp_err    = r_rsp_err;
`else
    assign rsp_err    = 1'b0;
`endif

    mem_access_ctrl_lane_align u_lane_align (
        .i_size     (r_size),
        .i_lane     (r_lane),
        .i_unsigned (r_unsigned),
        .i_rword    (readMemData),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_size      <= SZ_BYTE;
            r_lane      <= '0;
            r_unsigned  <= 1'b0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wmem      <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_size      <= w_size;
                        r_lane      <= w_lane;
                        r_unsigned  <= req_unsigned;
                        r_wdata     <= req_wdata;
                        r_addr      <= req_addr[AW+1:2];
                        r_cnt       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                        r_rsp_err   <= 1'b0;
                        if (w_misalign) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else
`endif
                        if (!req_write) begin
                            r_mem_rd <= 1'b1;
                            r_state  <= RD_WAIT;
                        end else if (w_size == SZ_WORD) begin
                            r_wmem   <= req_wdata;
                            r_mem_wr <= 1'b1;
                            r_state  <= WR;
                        end else begin
                            r_mem_rd <= 1'b1;
                            r_state  <= RMW_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    r_mem_rd <= 1'b0;
                    r_cnt    <= r_cnt + 3'd1;
                    if (w_hit) begin
                        r_rsp_rdata <= w_load;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RMW_WAIT: begin
                    r_mem_rd <= 1'b0;
                    r_cnt    <= r_cnt + 3'd1;
                    if (w_hit) begin
                        r_wmem   <= w_merge;
                        r_mem_wr <= 1'b1;
                        r_state  <= WR;
                    end
                end
                WR: begin
                    r_mem_wr    <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign dataAddress  = r_addr;
    assign writeMemData = r_wmem;
    assign memRead      = r_mem_rd;
    assign memWrite     = r_mem_wr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a 1-cycle-latency d_mem model.
module tb_mem_access_ctrl;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [AW+1:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [AW-1:0] dataAddress;
    logic [31:0] writeMemData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readMemData = '0;

    logic [31:0] mem [256];
    logic [32:0] sb [$];
    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int overlap = 0;
    int wr_long = 0;
    logic prev_wr = 1'b0;

    mem_access_ctrl #(.READ_LAT(1), .WIDTH(32), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dataAddress  (dataAddress),
        .writeMemData (writeMemData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .readMemData  (readMemData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWrite) mem[dataAddress] <= writeMemData;
        if (memRead)  readMemData <= mem[dataAddress];
        if (memRead)  rd_cnt <= rd_cnt + 1;
        if (memWrite) wr_cnt <= wr_cnt + 1;
        if (memRead && memWrite) overlap <= overlap + 1;
        if (prev_wr && memWrite) wr_long <= wr_long + 1;
        prev_wr <= memWrite;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every retiring response is matched against the oldest expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got response %h with nothing expected", rsp_rdata);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e[31:0]);
                chk("rsp_err", 32'(rsp_err), 32'(e[32]));
            end
        end
    end

    task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [AW+1:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                         input int hold);
        int n;
        int lat;
        sb.push_back({exp_e, exp_d});
        @(negedge clk);
        rsp_ready    = (hold == 0);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({name, "_accept_timeout"}, 32'(n), 32'(0));
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        if (lat >= 30) chk({name, "_rsp_timeout"}, 32'(lat), 32'(0));
        if (exp_lat > 0) chk({name, "_latency"}, 32'(lat + 1), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, "_hold_rdata"}, rsp_rdata, exp_d);
            chk({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 10) chk({name, "_retire_timeout"}, 32'(n), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_memRead", 32'(memRead), 32'd0);
        chk("rst_memWrite", 32'(memWrite), 32'd0);
        chk("rst_dataAddress", 32'(dataAddress), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        issue("st_word", 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        chk("mem_deadbeef", mem[4], 32'hDEADBEEF);
        issue("ld_word", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

        issue("st_80ff", 1'b1, 2'd2, 1'b0, 10'h010, 32'h80FF0000, 32'h0, 1'b0, 2, 0);
        issue("ld_b13_s", 1'b0, 2'd0, 1'b0, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
        issue("ld_b13_u", 1'b0, 2'd0, 1'b1, 10'h013, 32'h0, 32'h00000080, 1'b0, 3, 0);
        issue("ld_b12_s", 1'b0, 2'd0, 1'b0, 10'h012, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0);
        issue("ld_h12_s", 1'b0, 2'd1, 1'b0, 10'h012, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0);
        issue("ld_h12_u", 1'b0, 2'd1, 1'b1, 10'h012, 32'h0, 32'h000080FF, 1'b0, 3, 0);

        issue("st_aabb", 1'b1, 2'd2, 1'b0, 10'h010, 32'hAABBCCDD, 32'h0, 1'b0, 2, 0);
        r0 = rd_cnt;
        w0 = wr_cnt;
        issue("st_h12", 1'b1, 2'd1, 1'b0, 10'h012, 32'h00001234, 32'h0, 1'b0, 4, 0);
        chk("rmw_reads", 32'(rd_cnt - r0), 32'd1);
        chk("rmw_writes", 32'(wr_cnt - w0), 32'd1);
        chk("mem_1234ccdd", mem[4], 32'h1234CCDD);
        issue("st_b11", 1'b1, 2'd0, 1'b0, 10'h011, 32'hFFFFFF5A, 32'h0, 1'b0, 4, 0);
        chk("mem_12345add", mem[4], 32'h12345ADD);
        issue("st_b10", 1'b1, 2'd0, 1'b0, 10'h010, 32'h00000077, 32'h0, 1'b0, 4, 0);
        chk("mem_12345a77", mem[4], 32'h12345A77);

        issue("ld_hold", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h12345A77, 1'b0, 3, 5);
        issue("ld_sz3", 1'b0, 2'd3, 1'b0, 10'h010, 32'h0, 32'h12345A77, 1'b0, 3, 0);

        r0 = rd_cnt;
`ifdef MEM_MISALIGN_TRAP_EN
        issue("ld_w11_trap", 1'b0, 2'd2, 1'b0, 10'h011, 32'h0, 32'h0, 1'b1, 0, 0);
        issue("ld_h13_trap", 1'b0, 2'd1, 1'b0, 10'h013, 32'h0, 32'h0, 1'b1, 0, 0);
        chk("trap_no_reads", 32'(rd_cnt - r0), 32'd0);
`else
        issue("ld_w11_align", 1'b0, 2'd2, 1'b0, 10'h011, 32'h0, 32'h12345A77, 1'b0, 3, 0);
        issue("ld_h13_align", 1'b0, 2'd1, 1'b0, 10'h013, 32'h0, 32'h00001234, 1'b0, 3, 0);
        chk("align_reads", 32'(rd_cnt - r0), 32'd2);
`endif

        issue("st_1122", 1'b1, 2'd2, 1'b0, 10'h014, 32'h11223344, 32'h0, 1'b0, 2, 0);
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 10'h014;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("wr_strobe_before_rst", 32'(memWrite), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("wr_strobe_after_rst", 32'(memWrite), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mem_unchanged", mem[5], 32'h11223344);

        repeat (2) @(posedge clk);
        #1;
        chk("rd_wr_overlap", 32'(overlap), 32'd0);
        chk("wr_pulse_width", 32'(wr_long), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
